present_sbox_layer: RTL and testbench
=====================================

# present_sbox_layer

Parametrised, handshaked PRESENT substitution layer. It applies the PRESENT S-box, or its inverse, to every 4-bit nibble of a STATE_W-bit word. The work is spread over STEPS = STATE_W/(4*LANES) clock cycles, with LANES S-box instances in hardware. It sits between the key-addition and permutation stages of the round datapath and lets the team trade area (LANES) against latency.

## Interface

Parameters:
- STATE_W, default 64: word width in bits. Must be a multiple of 4.
- LANES, default 4: S-boxes evaluated per cycle. Must be in 1..STATE_W/4 and divide STATE_W/4.
- Illegal parameter combinations cause an elaboration-time error.

Ports:
- clk  input  1  clock; all state updates on the rising edge.
- rst  input  1  synchronous, active-high reset.
- in_valid  input  1  in_data/in_inv are valid.
- in_ready  output  1  block can accept a word; equals (state==IDLE) && !rst.
- in_data  input  STATE_W  word to substitute.
- in_inv  input  1  0 = forward S-box, 1 = inverse S-box; sampled with the word.
- out_valid  output  1  out_data holds a finished result.
- out_ready  input  1  downstream accepts the result.
- out_data  output  STATE_W  substituted word; driven directly from the working register.
- busy  output  1  state != IDLE.

## Operation

Tables, indexed by nibble value 0..F:
- Forward S: C,5,6,B,9,0,A,D,3,E,F,8,4,7,1,2.
- Inverse S⁻¹: 5,E,F,8,C,1,2,D,B,4,6,3,0,7,9,A.

Nibble and step mapping:
- Nibble i = bits [4i+3:4i], i = 0..STATE_W/4-1. Nibble value x is replaced by S[x] or S⁻¹[x].
- Step k (k = 0..STEPS-1) substitutes nibbles k*LANES .. k*LANES+LANES-1 in place in the working register. All other nibbles hold.

Registers: working register `wr`, mode bit `inv_q`, step counter `cnt` of ceil(log2(STEPS)) bits, minimum 1.

State machine (IDLE, RUN, DONE):
- IDLE: in_ready=1. On in_valid, load wr<=in_data, inv_q<=in_inv, cnt<=0, and go to RUN.
- RUN: each cycle, substitute nibble group cnt using inv_q.
  - If cnt==STEPS-1, go to DONE and set cnt<=0.
  - Otherwise cnt<=cnt+1.
  - in_valid is ignored.
- DONE: out_valid=1; wr, inv_q and out_data hold.
  - On out_ready, go to IDLE.
  - A new word is not accepted in the same cycle, so there is no bypass.
- Counter wrap: cnt never exceeds STEPS-1. With STEPS=1, cnt stays 0 and RUN lasts exactly one cycle.

Reset:
- rst=1 forces state=IDLE, wr=0, inv_q=0, cnt=0.
- Resulting output values: out_valid=0, out_data=0, busy=0, and in_ready=0 while rst is high.
- Reset in any state, including mid-RUN or DONE, discards the word. No out_valid is produced for it.
- rst has priority over every handshake in the same cycle.

## Timing

- Accept cycle A is the cycle with in_valid && in_ready. The word is captured at the end of A.
- RUN occupies cycles A+1 .. A+STEPS.
- out_valid is first high in cycle A+STEPS+1 and stays high until the cycle where out_ready=1, inclusive.
- in_ready returns high in the cycle after the output handshake.
- Throughput: at most one word per STEPS+2 cycles with no backpressure.
- out_data is registered and stable throughout DONE. Its value during RUN is intermediate and not meaningful.
- There is no combinational path from in_valid or out_ready to in_ready or out_valid. in_ready depends only on state and rst.

## Test plan

- Forward: STATE_W=64, LANES=4, in_data=64'h0123456789ABCDEF, in_inv=0, out_ready=1 → out_valid first high in cycle A+5 with out_data=64'hC56B90AD3EF84712; in_ready high again at A+6.
- Inverse round trip: in_data=64'hC56B90AD3EF84712, in_inv=1 → out_data=64'h0123456789ABCDEF. Also drive 256 random words forward then inverse → identity.
- Backpressure: hold out_ready=0 for 10 cycles in DONE while toggling in_valid and in_data → out_valid=1, out_data constant, in_ready=0, busy=1 throughout. One out_ready pulse → exactly one transfer.
- Reset mid-RUN: assert rst in cycle A+2 for one cycle → at A+3, busy=0, out_data=0, out_valid=0 with no later out_valid for that word. in_ready=1 at A+3 (rst low), and the next word processes correctly.
- Lane extremes:
  - LANES=16 (STEPS=1), in_data=0 → out_data=64'hCCCCCCCCCCCCCCCC, out_valid at A+2.
  - LANES=1 (STEPS=16), in_data=64'hFFFFFFFFFFFFFFFF → 64'h2222222222222222, out_valid at A+17.
  - STATE_W=16, LANES=2, in_data=16'h5A5A, inv=0 → 16'h0F0F at A+3.
- Random regression: 2000 words with random in_inv, random in_valid gaps and random out_ready → scoreboard against a software table model. Check that there are no drops or duplicates and that latency is exactly STEPS+1 from accept.

Source files
------------

// File: rtl/present_sbox_layer.sv
`default_nettype none
// ============================================================================
// Module      : present_sbox_layer
// Description : Handshaked PRESENT S-box / inverse S-box layer, LANES nibbles
//               substituted per cycle over STATE_W/(4*LANES) steps.
// Revision    : 1.0  initial release
// ============================================================================
module present_sbox_layer #(
    parameter int STATE_W = 64,
    parameter int LANES   = 4
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               in_valid,
    output logic               in_ready,
    input  logic [STATE_W-1:0] in_data,
    input  logic               in_inv,
    output logic               out_valid,
    input  logic               out_ready,
    output logic [STATE_W-1:0] out_data,
    output logic               busy
);

    localparam int c_nibbles = STATE_W / 4;
    localparam int c_steps   = (LANES > 0) ? (c_nibbles / LANES) : 1;
    localparam int c_cnt_w   = (c_steps > 1) ? $clog2(c_steps) : 1;

    localparam logic [c_cnt_w-1:0] c_cnt_last = c_cnt_w'(c_steps - 1);
    localparam logic [c_cnt_w-1:0] c_cnt_one  = c_cnt_w'(1);

    localparam logic [1:0] c_st_idle = 2'd0;
    localparam logic [1:0] c_st_run  = 2'd1;
    localparam logic [1:0] c_st_done = 2'd2;

    generate
        if ((STATE_W < 4) || ((STATE_W % 4) != 0) || (LANES < 1) ||
            (LANES > c_nibbles) || ((c_nibbles % LANES) != 0)) begin : g_param_check
            $error("present_sbox_layer: illegal STATE_W/LANES combination");
        end
    endgenerate

    function automatic logic [3:0] sbox_nibble(input logic [3:0] x, input logic inv);
        logic [3:0] y;
        y = 4'h0;
        if (!inv) begin
            case (x)
                4'h0: y = 4'hC;
                4'h1: y = 4'h5;
                4'h2: y = 4'h6;
                4'h3: y = 4'hB;
                4'h4: y = 4'h9;
                4'h5: y = 4'h0;
                4'h6: y = 4'hA;
                4'h7: y = 4'hD;
                4'h8: y = 4'h3;
                4'h9: y = 4'hE;
                4'hA: y = 4'hF;
                4'hB: y = 4'h8;
                4'hC: y = 4'h4;
                4'hD: y = 4'h7;
                4'hE: y = 4'h1;
                default: y = 4'h2;
            endcase
        end else begin
            case (x)
                4'h0: y = 4'h5;
                4'h1: y = 4'hE;
                4'h2: y = 4'hF;
                4'h3: y = 4'h8;
                4'h4: y = 4'hC;
                4'h5: y = 4'h1;
                4'h6: y = 4'h2;
                4'h7: y = 4'hD;
                4'h8: y = 4'hB;
                4'h9: y = 4'h4;
                4'hA: y = 4'h6;
                4'hB: y = 4'h3;
                4'hC: y = 4'h0;
                4'hD: y = 4'h7;
                4'hE: y = 4'h9;
                default: y = 4'hA;
            endcase
        end
        return y;
    endfunction

    logic [1:0]         r_state;
    logic [STATE_W-1:0] r_wr;
    logic               r_inv;
    logic [c_cnt_w-1:0] r_cnt;
    logic [STATE_W-1:0] w_wr_sub;

    // Only the nibble group selected by r_cnt is rewritten; the rest pass through.
    always_comb begin
        w_wr_sub = r_wr;
        for (int l = 0; l < LANES; l++) begin
            w_wr_sub[(int'(r_cnt) * LANES + l) * 4 +: 4] =
                sbox_nibble(r_wr[(int'(r_cnt) * LANES + l) * 4 +: 4], r_inv);
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= c_st_idle;
            r_wr    <= '0;
            r_inv   <= 1'b0;
            r_cnt   <= '0;
        end else begin
            case (r_state)
                c_st_idle: begin
                    if (in_valid) begin
                        r_wr    <= in_data;
                        r_inv   <= in_inv;
                        r_cnt   <= '0;
                        r_state <= c_st_run;
                    end
                end
                c_st_run: begin
                    r_wr <= w_wr_sub;
                    if (r_cnt == c_cnt_last) begin
                        r_cnt   <= '0;
                        r_state <= c_st_done;
                    end else begin
                        r_cnt <= r_cnt + c_cnt_one;
                    end
                end
                c_st_done: begin
                    if (out_ready) begin
                        r_state <= c_st_idle;
                    end
                end
                default: begin
                    r_state <= c_st_idle;
                end
            endcase
        end
    end

    assign in_ready  = (r_state == c_st_idle) && !rst;
    assign out_valid = (r_state == c_st_done);
    assign busy      = (r_state != c_st_idle);
    assign out_data  = r_wr;

endmodule
`default_nettype wire

// File: tb/tb_present_sbox_layer.sv
`default_nettype none
// ============================================================================
// Module      : tb_present_sbox_layer
// Description : Directed and randomised checks of present_sbox_layer across
//               four lane configurations.
// Revision    : 1.0  initial release
// ============================================================================
module tb_present_sbox_layer;

    localparam int c_n_rand = 2000;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic [3:0]  iv   = '0;
    logic [3:0]  inv_v = '0;
    logic [3:0]  ordy = 4'hF;
    logic [63:0] id [4];
    logic [3:0]  in_ready_v, out_valid_v, busy_v;
    logic [63:0] od0, od1, od2;
    logic [15:0] od3;

    int checks = 0;
    int errors = 0;
    int cyc    = 0;

    logic [3:0] c_sf [16] = '{4'hC, 4'h5, 4'h6, 4'hB, 4'h9, 4'h0, 4'hA, 4'hD,
                              4'h3, 4'hE, 4'hF, 4'h8, 4'h4, 4'h7, 4'h1, 4'h2};
    logic [3:0] c_si [16] = '{4'h5, 4'hE, 4'hF, 4'h8, 4'hC, 4'h1, 4'h2, 4'hD,
                              4'hB, 4'h4, 4'h6, 4'h3, 4'h0, 4'h7, 4'h9, 4'hA};

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    present_sbox_layer #(.STATE_W(64), .LANES(4)) u_dut0 (
        .clk(clk), .rst(rst), .in_valid(iv[0]), .in_ready(in_ready_v[0]),
        .in_data(id[0]), .in_inv(inv_v[0]), .out_valid(out_valid_v[0]),
        .out_ready(ordy[0]), .out_data(od0), .busy(busy_v[0]));
    present_sbox_layer #(.STATE_W(64), .LANES(16)) u_dut1 (
        .clk(clk), .rst(rst), .in_valid(iv[1]), .in_ready(in_ready_v[1]),
        .in_data(id[1]), .in_inv(inv_v[1]), .out_valid(out_valid_v[1]),
        .out_ready(ordy[1]), .out_data(od1), .busy(busy_v[1]));
    present_sbox_layer #(.STATE_W(64), .LANES(1)) u_dut2 (
        .clk(clk), .rst(rst), .in_valid(iv[2]), .in_ready(in_ready_v[2]),
        .in_data(id[2]), .in_inv(inv_v[2]), .out_valid(out_valid_v[2]),
        .out_ready(ordy[2]), .out_data(od2), .busy(busy_v[2]));
    present_sbox_layer #(.STATE_W(16), .LANES(2)) u_dut3 (
        .clk(clk), .rst(rst), .in_valid(iv[3]), .in_ready(in_ready_v[3]),
        .in_data(id[3][15:0]), .in_inv(inv_v[3]), .out_valid(out_valid_v[3]),
        .out_ready(ordy[3]), .out_data(od3), .busy(busy_v[3]));

    function automatic logic [63:0] get_od(input int j);
        case (j)
            0: return od0;
            1: return od1;
            2: return od2;
            default: return {48'h0, od3};
        endcase
    endfunction

    function automatic logic [63:0] model(input logic [63:0] d, input logic inv_b, input int nib);
        logic [63:0] r;
        r = d;
        for (int i = 0; i < nib; i++)
            r[i*4 +: 4] = inv_b ? c_si[d[i*4 +: 4]] : c_sf[d[i*4 +: 4]];
        return r;
    endfunction

    // Drives one word with out_ready=1; reports accept readiness, latency from
    // accept cycle to first out_valid, result, and in_ready one cycle later.
    task automatic run_word(input int j, input logic [63:0] d, input logic inv_b,
                            output logic rdy0, output int lat, output logic [63:0] res,
                            output logic rdy_after);
        iv[j] = 1'b1; id[j] = d; inv_v[j] = inv_b; ordy[j] = 1'b1;
        rdy0 = in_ready_v[j];
        @(posedge clk); #1;
        iv[j] = 1'b0;
        lat = 1;
        while (!out_valid_v[j] && lat < 40) begin
            @(posedge clk); #1;
            lat++;
        end
        res = get_od(j);
        @(posedge clk); #1;
        rdy_after = in_ready_v[j] && !out_valid_v[j];
    endtask

    task automatic test_reset();
        rst = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        for (int j = 0; j < 4; j++) begin
            checks++;
            if (out_valid_v[j] !== 1'b0 || get_od(j) !== 64'h0 || busy_v[j] !== 1'b0 ||
                in_ready_v[j] !== 1'b0) begin
                errors++;
                $display("FAIL reset_state dut%0d: valid=%b data=%h busy=%b rdy=%b, want 0/0/0/0",
                         j, out_valid_v[j], get_od(j), busy_v[j], in_ready_v[j]);
            end
        end
        rst = 1'b0;
        #1;
        checks++;
        if (in_ready_v !== 4'hF) begin
            errors++;
            $display("FAIL reset_release in_ready=%b want 1111", in_ready_v);
        end
        @(posedge clk); #1;
    endtask

    task automatic test_forward();
        logic r0, ra; int lat; logic [63:0] res;
        run_word(0, 64'h0123456789ABCDEF, 1'b0, r0, lat, res, ra);
        checks++;
        if (r0 !== 1'b1 || lat != 5 || ra !== 1'b1) begin
            errors++;
            $display("FAIL fwd_timing rdy=%b lat=%0d rdy_after=%b want 1/5/1", r0, lat, ra);
        end
        checks++;
        if (res !== 64'hC56B90AD3EF84712) begin
            errors++;
            $display("FAIL fwd_data got %h want C56B90AD3EF84712", res);
        end
    endtask

    task automatic test_inverse_roundtrip();
        logic r0, ra; int lat; logic [63:0] res, d, f;
        run_word(0, 64'hC56B90AD3EF84712, 1'b1, r0, lat, res, ra);
        checks++;
        if (res !== 64'h0123456789ABCDEF || lat != 5) begin
            errors++;
            $display("FAIL inv_data got %h lat=%0d want 0123456789ABCDEF lat=5", res, lat);
        end
        for (int n = 0; n < 256; n++) begin
            d = {$urandom, $urandom};
            f = model(d, 1'b0, 16);
            run_word(0, d, 1'b0, r0, lat, res, ra);
            checks++;
            if (res !== f) begin
                errors++;
                $display("FAIL rt_fwd[%0d] got %h want %h", n, res, f);
            end
            run_word(0, res, 1'b1, r0, lat, res, ra);
            checks++;
            if (res !== d) begin
                errors++;
                $display("FAIL rt_inv[%0d] got %h want %h", n, res, d);
            end
        end
    endtask

    task automatic test_backpressure();
        int w;
        iv[0] = 1'b1; id[0] = 64'h0123456789ABCDEF; inv_v[0] = 1'b0; ordy[0] = 1'b0;
        @(posedge clk); #1;
        iv[0] = 1'b0;
        w = 0;
        while (!out_valid_v[0] && w < 40) begin
            @(posedge clk); #1;
            w++;
        end
        for (int c = 0; c < 10; c++) begin
            iv[0] = c[0];
            id[0] = {$urandom, $urandom};
            inv_v[0] = c[1];
            checks++;
            if (out_valid_v[0] !== 1'b1 || od0 !== 64'hC56B90AD3EF84712 ||
                in_ready_v[0] !== 1'b0 || busy_v[0] !== 1'b1) begin
                errors++;
                $display("FAIL bp_hold[%0d] valid=%b data=%h rdy=%b busy=%b want 1/C56B90AD3EF84712/0/1",
                         c, out_valid_v[0], od0, in_ready_v[0], busy_v[0]);
            end
            @(posedge clk); #1;
        end
        iv[0] = 1'b0;
        ordy[0] = 1'b1;
        @(posedge clk); #1;
        ordy[0] = 1'b0;
        checks++;
        if (out_valid_v[0] !== 1'b0 || in_ready_v[0] !== 1'b1 || busy_v[0] !== 1'b0) begin
            errors++;
            $display("FAIL bp_release valid=%b rdy=%b busy=%b want 0/1/0",
                     out_valid_v[0], in_ready_v[0], busy_v[0]);
        end
        for (int c = 0; c < 5; c++) begin
            @(posedge clk); #1;
            checks++;
            if (out_valid_v[0] !== 1'b0) begin
                errors++;
                $display("FAIL bp_single_xfer[%0d] out_valid=%b want 0", c, out_valid_v[0]);
            end
        end
        ordy[0] = 1'b1;
    endtask

    task automatic test_reset_mid_run();
        logic r0, ra; int lat; logic [63:0] res;
        iv[0] = 1'b1; id[0] = 64'hFEDCBA9876543210; inv_v[0] = 1'b0; ordy[0] = 1'b1;
        @(posedge clk); #1;
        iv[0] = 1'b0;
        @(posedge clk); #1;
        rst = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0;
        #1;
        checks++;
        if (busy_v[0] !== 1'b0 || od0 !== 64'h0 || out_valid_v[0] !== 1'b0 ||
            in_ready_v[0] !== 1'b1) begin
            errors++;
            $display("FAIL rst_mid_run busy=%b data=%h valid=%b rdy=%b want 0/0/0/1",
                     busy_v[0], od0, out_valid_v[0], in_ready_v[0]);
        end
        for (int c = 0; c < 10; c++) begin
            @(posedge clk); #1;
            checks++;
            if (out_valid_v[0] !== 1'b0) begin
                errors++;
                $display("FAIL rst_discard[%0d] out_valid=%b want 0", c, out_valid_v[0]);
            end
        end
        run_word(0, 64'h0123456789ABCDEF, 1'b0, r0, lat, res, ra);
        checks++;
        if (res !== 64'hC56B90AD3EF84712 || lat != 5 || r0 !== 1'b1) begin
            errors++;
            $display("FAIL rst_next_word got %h lat=%0d rdy=%b want C56B90AD3EF84712/5/1", res, lat, r0);
        end
    endtask

    task automatic test_lane_extremes();
        logic r0, ra; int lat; logic [63:0] res;
        run_word(1, 64'h0, 1'b0, r0, lat, res, ra);
        checks++;
        if (res !== 64'hCCCCCCCCCCCCCCCC || lat != 2 || ra !== 1'b1) begin
            errors++;
            $display("FAIL lanes16 got %h lat=%0d rdy_after=%b want CCCCCCCCCCCCCCCC/2/1", res, lat, ra);
        end
        run_word(2, 64'hFFFFFFFFFFFFFFFF, 1'b0, r0, lat, res, ra);
        checks++;
        if (res !== 64'h2222222222222222 || lat != 17 || ra !== 1'b1) begin
            errors++;
            $display("FAIL lanes1 got %h lat=%0d rdy_after=%b want 2222222222222222/17/1", res, lat, ra);
        end
        run_word(2, 64'h0123456789ABCDEF, 1'b1, r0, lat, res, ra);
        checks++;
        if (res !== 64'h5EF8C12DB463079A) begin
            errors++;
            $display("FAIL lanes1_inv got %h want 5EF8C12DB463079A", res);
        end
        run_word(3, 64'h5A5A, 1'b0, r0, lat, res, ra);
        checks++;
        if (res !== 64'h0F0F || lat != 3 || ra !== 1'b1) begin
            errors++;
            $display("FAIL w16_l2 got %h lat=%0d rdy_after=%b want 0F0F/3/1", res, lat, ra);
        end
        run_word(3, 64'h0F0F, 1'b1, r0, lat, res, ra);
        checks++;
        if (res !== 64'h5A5A) begin
            errors++;
            $display("FAIL w16_l2_inv got %h want 5A5A", res);
        end
    endtask

    task automatic test_random_regression();
        logic [63:0] exp_q [$];
        int          acc_q [$];
        int          sent = 0;
        int          recv = 0;
        fork
            begin : drv
                int budget;
                int gap;
                logic [63:0] d;
                logic ib;
                while (sent < c_n_rand) begin
                    gap = $urandom_range(0, 3);
                    iv[0] = 1'b0;
                    repeat (gap) begin
                        id[0] = {$urandom, $urandom};
                        @(posedge clk); #1;
                    end
                    d = {$urandom, $urandom};
                    ib = 1'($urandom_range(0, 1));
                    iv[0] = 1'b1; id[0] = d; inv_v[0] = ib;
                    budget = 0;
                    while (!in_ready_v[0] && budget < 200) begin
                        @(posedge clk); #1;
                        budget++;
                    end
                    if (budget >= 200) begin
                        checks++;
                        errors++;
                        $display("FAIL rand_accept_timeout after %0d words", sent);
                        break;
                    end
                    exp_q.push_back(model(d, ib, 16));
                    acc_q.push_back(cyc);
                    sent++;
                    @(posedge clk); #1;
                end
                iv[0] = 1'b0;
            end
            begin : mon
                int   mbudget = 0;
                logic prev_v  = 1'b0;
                logic [63:0] e;
                int   a;
                while (recv < c_n_rand && mbudget < 60000) begin
                    @(posedge clk); #1;
                    mbudget++;
                    ordy[0] = ($urandom_range(0, 2) != 0);
                    if (out_valid_v[0]) begin
                        if (exp_q.size() == 0) begin
                            checks++;
                            errors++;
                            $display("FAIL rand_duplicate out_valid with nothing outstanding, data=%h", od0);
                        end else begin
                            if (!prev_v) begin
                                a = acc_q[0];
                                checks++;
                                if (cyc - a != 5) begin
                                    errors++;
                                    $display("FAIL rand_latency word %0d got %0d want 5", recv, cyc - a);
                                end
                            end
                            if (ordy[0]) begin
                                e = exp_q.pop_front();
                                void'(acc_q.pop_front());
                                checks++;
                                if (od0 !== e) begin
                                    errors++;
                                    $display("FAIL rand_data word %0d got %h want %h", recv, od0, e);
                                end
                                recv++;
                            end
                        end
                    end
                    prev_v = out_valid_v[0] && !ordy[0];
                end
                ordy[0] = 1'b1;
            end
        join
        checks++;
        if (recv != c_n_rand || exp_q.size() != 0) begin
            errors++;
            $display("FAIL rand_count received %0d outstanding %0d want %0d/0", recv, exp_q.size(), c_n_rand);
        end
        for (int c = 0; c < 8; c++) begin
            @(posedge clk); #1;
            checks++;
            if (out_valid_v[0] !== 1'b0) begin
                errors++;
                $display("FAIL rand_tail_extra out_valid=%b want 0", out_valid_v[0]);
            end
        end
    endtask

    initial begin
        for (int j = 0; j < 4; j++) id[j] = 64'h0;
        test_reset();
        test_forward();
        test_inverse_roundtrip();
        test_backpressure();
        test_reset_mid_run();
        test_lane_extremes();
        test_random_regression();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire
